// File: rtl/pat_seq_ctrl.sv
// rtl/pat_seq_ctrl.sv - programmable slot-table pattern sequencer with valid/ready output
//
// Purpose:
//   Holds a DEPTH-entry table of {dv_flag, data} slots. A start pulse in IDLE
//   steps through slots 0..len, repeating rpt passes (rpt=0 runs until abort),
//   and presents each slot on o_dv/o_data with a valid/ready handshake.
//   Gap slots (dv_flag=0) are shown for exactly one cycle. Data slots hold
//   until o_dv&i_ready.
//
// Ports:
//   sclk        clock
//   rst         synchronous reset, active-high
//   i_cfg_we    table write strobe, accepted in IDLE only
//   i_cfg_addr  slot to write
//   i_cfg_data  {dv_flag, data} written to the slot
//   i_len       index of the last slot, latched on accepted start
//   i_rpt       pass count (0 = endless), latched on accepted start
//   i_start     start pulse, honoured in IDLE only
//   i_abort     stop the run, honoured in RUN only
//   i_ready     downstream accepts o_data while o_dv=1
//   o_dv        data valid
//   o_data      slot data, 0 whenever o_dv=0
//   o_busy      high in RUN and DONE
//   o_done      one-cycle pulse on normal completion
//   o_err       sticky flag: table write attempted while busy

module pat_seq_ctrl #(
  parameter int DW    = 8,
  parameter int DEPTH = 8,
  parameter int AW    = 3,
  parameter int RPT_W = 8
) (
  input  logic             sclk,
  input  logic             rst,
  input  logic             i_cfg_we,
  input  logic [AW-1:0]    i_cfg_addr,
  input  logic [DW:0]      i_cfg_data,
  input  logic [AW-1:0]    i_len,
  input  logic [RPT_W-1:0] i_rpt,
  input  logic             i_start,
  input  logic             i_abort,
  input  logic             i_ready,
  output logic             o_dv,
  output logic [DW-1:0]    o_data,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [DW:0]      tbl_q [DEPTH];
  logic [DW:0]      tbl_d [DEPTH];
  logic [AW-1:0]    idx_q, idx_d;
  logic [RPT_W-1:0] pass_q, pass_d;
  logic [AW-1:0]    len_q, len_d;
  logic [RPT_W-1:0] rpt_q, rpt_d;
  logic             dv_q, dv_d;
  logic [DW-1:0]    data_q, data_d;
  logic             err_q, err_d;

  logic             load;
  logic [AW-1:0]    load_idx;
  logic [DW:0]      load_slot;
  logic [RPT_W-1:0] pass_inc;
  logic             consume;

  always_comb begin
    state_d   = state_q;
    tbl_d     = tbl_q;
    idx_d     = idx_q;
    pass_d    = pass_q;
    len_d     = len_q;
    rpt_d     = rpt_q;
    dv_d      = dv_q;
    data_d    = data_q;
    err_d     = err_q;
    load      = 1'b0;
    load_idx  = '0;
    load_slot = '0;
    pass_inc  = pass_q + 1'b1;
    // A gap slot is shown for one cycle whatever i_ready does.
    consume   = !dv_q || i_ready;

    if (i_cfg_we && (state_q != S_IDLE)) begin
      err_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (i_cfg_we) begin
          tbl_d[i_cfg_addr] = i_cfg_data;
        end
        if (i_start) begin
          state_d  = S_RUN;
          len_d    = i_len;
          rpt_d    = i_rpt;
          idx_d    = '0;
          pass_d   = '0;
          load     = 1'b1;
          load_idx = '0;
        end
      end
      S_RUN: begin
        // Abort wins over advancing; a transfer in this cycle still counts.
        if (i_abort) begin
          state_d = S_IDLE;
          dv_d    = 1'b0;
          data_d  = '0;
        end else if (consume) begin
          if (idx_q == len_q) begin
            idx_d  = '0;
            pass_d = pass_inc;
            if ((rpt_q != '0) && (pass_inc == rpt_q)) begin
              state_d = S_DONE;
              dv_d    = 1'b0;
              data_d  = '0;
            end else begin
              load     = 1'b1;
              load_idx = '0;
            end
          end else begin
            idx_d    = idx_q + 1'b1;
            load     = 1'b1;
            load_idx = idx_q + 1'b1;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Next slot goes straight into the output regs on the consuming edge,
    // so back-to-back data slots stream without bubbles.
    if (load) begin
      load_slot = tbl_q[load_idx];
      dv_d      = load_slot[DW];
      data_d    = load_slot[DW] ? load_slot[DW-1:0] : '0;
    end
  end

  always_ff @(posedge sclk) begin
    if (rst) begin
      state_q <= S_IDLE;
      for (int i = 0; i < DEPTH; i++) begin
        tbl_q[i] <= '0;
      end
      idx_q  <= '0;
      pass_q <= '0;
      len_q  <= '0;
      rpt_q  <= '0;
      dv_q   <= 1'b0;
      data_q <= '0;
      err_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      for (int i = 0; i < DEPTH; i++) begin
        tbl_q[i] <= tbl_d[i];
      end
      idx_q  <= idx_d;
      pass_q <= pass_d;
      len_q  <= len_d;
      rpt_q  <= rpt_d;
      dv_q   <= dv_d;
      data_q <= data_d;
      err_q  <= err_d;
    end
  end

  assign o_dv   = dv_q;
  assign o_data = data_q;
  assign o_busy = (state_q != S_IDLE);
  assign o_done = (state_q == S_DONE);
  assign o_err  = err_q;

endmodule

// File: tb/tb_pat_seq_ctrl.sv
// tb/tb_pat_seq_ctrl.sv - scoreboard bench for pat_seq_ctrl

module tb_pat_seq_ctrl;

  localparam int DW    = 8;
  localparam int DEPTH = 8;
  localparam int AW    = 3;
  localparam int RPT_W = 8;

  logic             sclk;
  logic             rst;
  logic             i_cfg_we;
  logic [AW-1:0]    i_cfg_addr;
  logic [DW:0]      i_cfg_data;
  logic [AW-1:0]    i_len;
  logic [RPT_W-1:0] i_rpt;
  logic             i_start;
  logic             i_abort;
  logic             i_ready;
  logic             o_dv;
  logic [DW-1:0]    o_data;
  logic             o_busy;
  logic             o_done;
  logic             o_err;

  pat_seq_ctrl #(.DW(DW), .DEPTH(DEPTH), .AW(AW), .RPT_W(RPT_W)) dut (
    .sclk       (sclk),
    .rst        (rst),
    .i_cfg_we   (i_cfg_we),
    .i_cfg_addr (i_cfg_addr),
    .i_cfg_data (i_cfg_data),
    .i_len      (i_len),
    .i_rpt      (i_rpt),
    .i_start    (i_start),
    .i_abort    (i_abort),
    .i_ready    (i_ready),
    .o_dv       (o_dv),
    .o_data     (o_data),
    .o_busy     (o_busy),
    .o_done     (o_done),
    .o_err      (o_err)
  );

  initial begin
    sclk = 1'b0;
    forever #5 sclk = ~sclk;
  end

  int          checks;
  int          errors;
  logic [7:0]  exp_q [$];
  bit          sb_on;
  bit          done_ok;
  logic [8:0]  m_tbl [DEPTH];
  bit          m_err;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge sclk);
    #1;
  endtask

  // Sampled on the falling edge: inputs and outputs of the current cycle are settled.
  task automatic monitor_step();
    logic [7:0] e;
    if (rst !== 1'b0) return;
    if (o_dv === 1'b1 && i_ready === 1'b1 && sb_on) begin
      if (exp_q.size() == 0) begin
        check("xfer_extra", 32'(o_data), 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check("xfer_data", 32'(o_data), 32'(e));
      end
    end
    if (o_dv !== 1'b1) check("data_zero_no_dv", 32'(o_data), 32'd0);
    if (o_done === 1'b1) begin
      check("done_allowed", 32'(done_ok), 32'd1);
      check("done_queue_empty", exp_q.size(), 32'd0);
    end
  endtask

  // Reference: every pass emits the data of the flagged slots 0..len, in order.
  task automatic push_expected(input int l, input int r);
    for (int p = 0; p < r; p++)
      for (int i = 0; i <= l; i++)
        if (m_tbl[i][8]) exp_q.push_back(m_tbl[i][7:0]);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < DEPTH; i++) m_tbl[i] = '0;
    m_err = 1'b0;
    exp_q.delete();
    sb_on = 1'b1;
    done_ok = 1'b0;
  endtask

  task automatic write_slot(input int addr, input logic [8:0] val, input bit accepted);
    i_cfg_we   = 1'b1;
    i_cfg_addr = AW'(addr);
    i_cfg_data = val;
    tick();
    i_cfg_we = 1'b0;
    if (accepted) m_tbl[addr] = val;
    else m_err = 1'b1;
  endtask

  task automatic start_run(input int l, input int r, input bit sb);
    i_len   = AW'(l);
    i_rpt   = RPT_W'(r);
    i_start = 1'b1;
    if (sb) begin
      push_expected(l, r);
      sb_on = 1'b1;
      done_ok = 1'b1;
    end else begin
      sb_on = 1'b0;
      done_ok = 1'b0;
    end
    tick();
    i_start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input bit rnd);
    int n = 0;
    while (o_done !== 1'b1 && n < budget) begin
      if (rnd) i_ready = ($urandom_range(0, 1) == 1);
      tick();
      n++;
    end
    check("done_seen", 32'(o_done), 32'd1);
    tick();
    check("busy_after_done", 32'(o_busy), 32'd0);
    check("done_one_cycle", 32'(o_done), 32'd0);
    done_ok = 1'b0;
  endtask

  initial begin
    logic [8:0] exp_seq [$];
    int n_hi;
    checks = 0;
    errors = 0;
    rst = 1'b1;
    i_cfg_we = 1'b0; i_cfg_addr = '0; i_cfg_data = '0;
    i_len = '0; i_rpt = '0; i_start = 1'b0; i_abort = 1'b0; i_ready = 1'b0;
    sb_on = 1'b1; done_ok = 1'b0; m_err = 1'b0;

    fork
      forever begin
        @(negedge sclk);
        monitor_step();
      end
    join_none

    // Reset state
    do_reset();
    check("reset_outputs", {o_dv, o_data, o_busy, o_done, o_err}, 32'd0);

    // Test 1: two passes, ready high, cycle-exact stream
    write_slot(0, {1'b1, 8'd7}, 1);
    write_slot(1, {1'b0, 8'd0}, 1);
    write_slot(2, {1'b1, 8'd5}, 1);
    i_ready = 1'b1;
    for (int p = 0; p < 2; p++)
      for (int i = 0; i <= 2; i++)
        exp_seq.push_back(m_tbl[i][8] ? m_tbl[i] : 9'd0);
    start_run(2, 2, 1);
    foreach (exp_seq[k]) begin
      check("t1_stream", {o_dv, o_data}, 32'(exp_seq[k]));
      check("t1_busy", 32'(o_busy), 32'd1);
      tick();
    end
    check("t1_done", {o_done, o_dv}, 32'b10);
    tick();
    check("t1_idle", {o_busy, o_done}, 32'd0);
    done_ok = 1'b0;

    // Test 2: data slot held while stalled, gap ignores ready
    i_ready = 1'b0;
    start_run(2, 1, 1);
    for (int c = 0; c < 3; c++) begin
      check("t2_hold", {o_dv, o_data}, {23'd0, 1'b1, 8'd7});
      tick();
    end
    check("t2_hold4", {o_dv, o_data}, {23'd0, 1'b1, 8'd7});
    i_ready = 1'b1;
    tick();
    check("t2_gap", {o_dv, o_data}, 32'd0);
    i_ready = 1'b0;
    tick();
    check("t2_after_gap", {o_dv, o_data}, {23'd0, 1'b1, 8'd5});
    i_ready = 1'b1;
    tick();
    check("t2_done", 32'(o_done), 32'd1);
    tick();
    done_ok = 1'b0;

    // Test 3: endless run, then abort
    write_slot(0, {1'b1, 8'hA5}, 1);
    i_ready = 1'b1;
    start_run(0, 0, 0);
    n_hi = 0;
    repeat (600) begin
      if (o_dv === 1'b1 && o_data === 8'hA5) n_hi++;
      tick();
    end
    check("t3_continuous", n_hi, 600);
    i_abort = 1'b1;
    tick();
    i_abort = 1'b0;
    check("t3_abort", {o_dv, o_data, o_busy, o_done}, 32'd0);
    repeat (3) begin
      tick();
      check("t3_no_done", {o_busy, o_done}, 32'd0);
    end

    // Test 4: write and start while busy are dropped, error is sticky
    write_slot(0, {1'b1, 8'h11}, 1);
    write_slot(1, {1'b1, 8'h22}, 1);
    write_slot(2, {1'b0, 8'h99}, 1);
    i_ready = 1'b1;
    start_run(2, 3, 1);
    tick();
    write_slot(0, {1'b1, 8'h33}, 0);
    i_len = 3'd0; i_rpt = 8'd1; i_start = 1'b1;
    tick();
    i_start = 1'b0;
    wait_done(100, 0);
    check("t4_err", 32'(o_err), 32'(m_err));
    start_run(0, 1, 1);
    wait_done(100, 0);
    check("t4_err_sticky", 32'(o_err), 32'd1);

    // Test 5: reset mid-run clears table and error
    write_slot(3, {1'b1, 8'h44}, 1);
    start_run(7, 0, 0);
    repeat (5) tick();
    do_reset();
    check("t5_reset_outputs", {o_dv, o_data, o_busy, o_done, o_err}, 32'd0);
    start_run(7, 1, 1);
    for (int c = 0; c < 8; c++) begin
      check("t5_cleared_slot", {o_dv, o_data, o_busy}, 32'd1);
      tick();
    end
    wait_done(2, 0);

    // Test 6: final slot stalled, done one cycle after last transfer
    write_slot(0, {1'b1, 8'h5A}, 1);
    write_slot(1, {1'b1, 8'hC3}, 1);
    i_ready = 1'b1;
    start_run(1, 1, 1);
    check("t6_first", {o_dv, o_data}, {23'd0, 1'b1, 8'h5A});
    tick();
    check("t6_last", {o_dv, o_data}, {23'd0, 1'b1, 8'hC3});
    i_ready = 1'b0;
    repeat (4) begin
      tick();
      check("t6_stall", {o_dv, o_data, o_done}, {22'd0, 1'b1, 8'hC3, 1'b0});
    end
    tick();
    check("t6_stall_end", {o_dv, o_data, o_done}, {22'd0, 1'b1, 8'hC3, 1'b0});
    i_ready = 1'b1;
    tick();
    check("t6_done", {o_done, o_dv}, 32'b10);
    tick();
    check("t6_idle", 32'(o_busy), 32'd0);
    done_ok = 1'b0;

    // Randomized runs against the reference
    for (int it = 0; it < 12; it++) begin
      for (int a = 0; a < DEPTH; a++)
        write_slot(a, {($urandom_range(0, 3) != 0), 8'($urandom_range(0, 255))}, 1);
      i_ready = ($urandom_range(0, 1) == 1);
      start_run(int'($urandom_range(0, 7)), int'($urandom_range(1, 3)), 1);
      wait_done(3000, 1);
      check("rand_queue_drained", exp_q.size(), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
